pila_subrutinas: RTL and testbench

// - LIFO return-address stack for CALL/RETURN; sits directly downstream of the control unit.
// - Driven by the control unit's activarPilaSubR (enable) and pushPilaSubR (1=push, 0=pop).
// - CALL pushes the return PC (PC+1) presented on din.
// - RETURN supplies the top entry on dout; the PC-source mux loads it in the same cycle.

---
 rtl/pila_subrutinas.sv | 82 ++++++++
 tb/tb_pila_subrutinas.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pila_subrutinas.sv
// rtl/pila_subrutinas.sv - LIFO return-address stack for CALL/RETURN.
// Build option: PILA_ERR_STICKY_EN makes ovf/unf hold until reset instead of pulsing.
module pila_subrutinas #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activar,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             unf
);

    localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_sp;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [AW-1:0]    w_top_idx;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SP_FULL);
    assign w_do_push = activar &  push & ~w_full;
    assign w_do_pop  = activar & ~push & ~w_empty;
    assign w_ovf_evt = activar &  push &  w_full;
    assign w_unf_evt = activar & ~push &  w_empty;
    // Low bits of sp-1; when sp==DEPTH the low bits are 0 and wrap to DEPTH-1.
    assign w_top_idx = r_sp[AW-1:0] - IDX_ONE;

    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[r_sp[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_sp <= r_sp + SP_ONE;
            end else if (w_do_pop) begin
                r_sp <= r_sp - SP_ONE;
            end
`ifdef PILA_ERR_STICKY_EN
            r_ovf <= r_ovf | w_ovf_evt;
            r_unf <= r_unf | w_unf_evt;
`else
            r_ovf <= w_ovf_evt;
            r_unf <= w_unf_evt;
`endif
        end
    end

    // Top entry is readable in the pop cycle itself so RETURN needs no extra cycle.
    assign dout  = w_empty ? '0 : r_mem[w_top_idx];
    assign empty = w_empty;
    assign full  = w_full;
    assign count = r_sp;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_pila_subrutinas.sv
// tb/tb_pila_subrutinas.sv - directed scoreboard bench for pila_subrutinas.
module tb_pila_subrutinas;

    logic       clk = 1'b0;
    logic       reset;
    logic       activar;
    logic       push;
    logic [9:0] din;
    logic [9:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       ovf;
    logic       unf;

    int vectors = 0;
    int miscompares = 0;
    int sb[$];

    pila_subrutinas #(.WIDTH(10), .DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .activar(activar), .push(push), .din(din),
        .dout(dout), .empty(empty), .full(full), .count(count), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [9:0] d);
        activar = 1'b1; push = 1'b1; din = d;
        if (sb.size() < 16) sb.push_back(int'(d));
        tick();
        activar = 1'b0;
    endtask

    task automatic do_pop(input string tag);
        int exp;
        activar = 1'b1; push = 1'b0;
        #2;
        exp = (sb.size() > 0) ? sb.pop_back() : 0;
        chk(tag, 32'(dout), 32'(exp));
        tick();
        activar = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset = 1'b1; activar = 1'b0; push = 1'b0; din = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);

        do_push(10'h005); do_push(10'h0A0); do_push(10'h3FF);
        chk("p3_count", 32'(count), 3);
        chk("p3_dout", 32'(dout), 32'h3FF);
        do_pop("pop_a"); do_pop("pop_b"); do_pop("pop_c");
        chk("p3_empty", 32'(empty), 1);

        for (int i = 0; i < 16; i++) do_push(10'(i));
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        do_push(10'h111);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_dout", 32'(dout), 15);
        chk("ovf_unf", 32'(unf), 0);
        tick();
`ifdef PILA_ERR_STICKY_EN
        chk("ovf_hold", 32'(ovf), 1);
`else
        chk("ovf_clear", 32'(ovf), 0);
`endif
        for (int i = 0; i < 16; i++) do_pop($sformatf("drain_%0d", i));
        chk("drain_empty", 32'(empty), 1);
        chk("drain_unf", 32'(unf), 0);

        do_reset();
        do_pop("unf_dout");
        chk("unf_set", 32'(unf), 1);
        chk("unf_count", 32'(count), 0);
        chk("unf_dout_after", 32'(dout), 0);
        tick();
`ifdef PILA_ERR_STICKY_EN
        chk("unf_hold", 32'(unf), 1);
`else
        chk("unf_clear", 32'(unf), 0);
`endif
        do_reset();
        chk("unf_reset", 32'(unf), 0);

        for (int i = 0; i < 4; i++) begin
            do_push(10'h001);
            chk($sformatf("alt_cnt1_%0d", i), 32'(count), 1);
            do_pop($sformatf("alt_pop_%0d", i));
            chk($sformatf("alt_cnt0_%0d", i), 32'(count), 0);
            chk($sformatf("alt_err_%0d", i), 32'({ovf, unf}), 0);
        end

        do_push(10'h2AA); do_push(10'h155);
        reset = 1'b1; activar = 1'b1; push = 1'b1; din = 10'h0FF;
        tick();
        reset = 1'b0; activar = 1'b0;
        sb.delete();
        chk("rstpush_count", 32'(count), 0);
        chk("rstpush_empty", 32'(empty), 1);
        chk("rstpush_dout", 32'(dout), 0);
        do_push(10'h0C3);
        do_pop("post_rst_pop");
        chk("post_rst_empty", 32'(empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
